// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: character-LCD bus sequencer; power-on init, byte writes with busy-flag polling
module lcd_bus_ctrl #(
  parameter int POR_CYCLES = 750000,
  parameter int T_SU = 2,
  parameter int T_EN = 12,
  parameter int T_HD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DQ_O,
  output logic       LCD_DQ_OE,
  input  logic [7:0] LCD_DQ_I
);
  typedef enum logic [2:0] {POR_WAIT, IDLE, W_SU, W_EN, W_HD, B_SU, B_EN, B_HD} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [1:0] idx;
  logic busy;
  logic unused_dq;
  assign unused_dq = ^LCD_DQ_I[6:0];
  function automatic logic [7:0] rom(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
  endfunction
  function automatic logic at_end(input logic [31:0] c, input int n);
    return c == 32'(n - 1);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= POR_WAIT;
      cnt <= '0;
      idx <= '0;
      busy <= 1'b0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
      LCD_ON <= 1'b0;
      LCD_BLON <= 1'b0;
      LCD_EN <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b0;
      LCD_DQ_O <= 8'h00;
      LCD_DQ_OE <= 1'b0;
    end else begin
      LCD_ON <= 1'b1;
      LCD_BLON <= 1'b1;
      cnt <= cnt + 32'd1;
      case (state)
        POR_WAIT: if (at_end(cnt, POR_CYCLES)) begin
          state <= W_SU;
          cnt <= '0;
          LCD_RS <= 1'b0;
          LCD_RW <= 1'b0;
          LCD_DQ_O <= rom(2'd0);
          LCD_DQ_OE <= 1'b1;
        end
        IDLE: begin
          cnt <= '0;
          if (req_valid && req_ready) begin
            state <= W_SU;
            req_ready <= 1'b0;
            LCD_RS <= req_rs;
            LCD_RW <= 1'b0;
            LCD_DQ_O <= req_data;
            LCD_DQ_OE <= 1'b1;
          end
        end
        W_SU: if (at_end(cnt, T_SU)) begin
          state <= W_EN;
          cnt <= '0;
          LCD_EN <= 1'b1;
        end
        W_EN: if (at_end(cnt, T_EN)) begin
          state <= W_HD;
          cnt <= '0;
          LCD_EN <= 1'b0;
        end
        W_HD: if (at_end(cnt, T_HD)) begin
          state <= B_SU;
          cnt <= '0;
          LCD_RS <= 1'b0;
          LCD_RW <= 1'b1;
          LCD_DQ_OE <= 1'b0;
        end
        B_SU: if (at_end(cnt, T_SU)) begin
          state <= B_EN;
          cnt <= '0;
          LCD_EN <= 1'b1;
        end
        B_EN: if (at_end(cnt, T_EN)) begin
          state <= B_HD;
          cnt <= '0;
          LCD_EN <= 1'b0;
          busy <= LCD_DQ_I[7];
        end
        B_HD: if (at_end(cnt, T_HD)) begin
          cnt <= '0;
          if (busy) state <= B_SU;
          else if (!init_done && idx != 2'd3) begin
            // RW drops and OE rises on the same edge, so they never overlap
            state <= W_SU;
            idx <= idx + 2'd1;
            LCD_RS <= 1'b0;
            LCD_RW <= 1'b0;
            LCD_DQ_O <= rom(idx + 2'd1);
            LCD_DQ_OE <= 1'b1;
          end else begin
            state <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: state <= POR_WAIT;
      endcase
    end
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: scoreboard bench; expected EN pulses are queued by stimulus and popped by a bus monitor
`timescale 1ns/1ps
module tb_lcd_bus_ctrl;
  localparam int POR = 20, TSU = 2, TEN = 4, THD = 2;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_rs = 1'b0;
  logic [7:0] req_data = 8'h00, LCD_DQ_I = 8'h00;
  logic req_ready, init_done, LCD_ON, LCD_BLON, LCD_EN, LCD_RS, LCD_RW, LCD_DQ_OE;
  logic [7:0] LCD_DQ_O;
  typedef struct {logic rw; logic rs; logic [7:0] d; logic bf;} pulse_t;
  pulse_t exp_q[$];
  int total = 0, bad = 0;
  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  always #5 clk = ~clk;
  lcd_bus_ctrl #(.POR_CYCLES(POR), .T_SU(TSU), .T_EN(TEN), .T_HD(THD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DQ_O(LCD_DQ_O),
    .LCD_DQ_OE(LCD_DQ_OE), .LCD_DQ_I(LCD_DQ_I)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask
  // One write pulse followed by nb busy reads and a final not-busy read
  task automatic push_xfer(input logic rs, input logic [7:0] d, input int nb);
    exp_q.push_back('{1'b0, rs, d, 1'b0});
    for (int i = 0; i <= nb; i++) exp_q.push_back('{1'b1, 1'b0, 8'h00, (i < nb)});
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(req_ready), 32'd1);
  endtask
  task automatic send(input logic rs, input logic [7:0] d, input int nb, input bit poke);
    req_rs = rs; req_data = d; req_valid = 1'b1;
    wait_ready("accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_xfer(rs, d, nb);
    chk("ready_drop", 32'(req_ready), 32'd0);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      req_rs = 1'b0; req_data = 8'hEE; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    wait_ready("done");
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic do_init();
    int n = 0;
    for (int i = 0; i < 4; i++) push_xfer(1'b0, init_rom[i], 0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    req_rs = 1'b1; req_data = 8'h5A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!init_done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_drained", 32'(exp_q.size()), 32'd0);
    chk("lcd_on", 32'({LCD_ON, LCD_BLON}), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_init", 32'(req_ready), 32'd1);
  endtask
  task automatic chk_reset(input string name);
    chk(name, 32'({LCD_EN, LCD_RS, LCD_RW, LCD_DQ_O, LCD_DQ_OE, LCD_ON, LCD_BLON, req_ready, init_done}), 32'd0);
  endtask
  initial begin : monitor
    logic [10:0] hist [TSU];
    logic [10:0] held, bus;
    logic en_d = 1'b0, first_en = 1'b1;
    int hi_cnt = 0, hd_left = 0, since_rel = 0;
    pulse_t p;
    forever begin
      @(negedge clk);
      bus = {LCD_RS, LCD_RW, LCD_DQ_OE, LCD_DQ_O};
      if (!rst_n) begin
        en_d = 1'b0; hd_left = 0; since_rel = 0; first_en = 1'b1;
      end else begin
        since_rel++;
        chk("rw_oe_excl", 32'(LCD_RW & LCD_DQ_OE), 32'd0);
        if (exp_q.size() != 0) chk("ready_while_busy", 32'(req_ready), 32'd0);
        if (LCD_EN && !en_d) begin
          if (first_en) chk("por_wait", 32'(since_rel >= POR), 32'd1);
          first_en = 1'b0;
          for (int i = 0; i < TSU; i++) chk("setup", 32'(hist[i]), 32'(bus));
          held = bus;
          hi_cnt = 1;
          chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            chk("rw", 32'(LCD_RW), 32'(p.rw));
            chk("oe", 32'(LCD_DQ_OE), 32'(!p.rw));
            chk("rs", 32'(LCD_RS), 32'(p.rs));
            if (!p.rw) chk("data", 32'(LCD_DQ_O), 32'(p.d));
            else LCD_DQ_I = {p.bf, 7'($urandom)};
          end
        end else if (LCD_EN) begin
          chk("en_stable", 32'(bus), 32'(held));
          hi_cnt++;
        end else if (en_d) begin
          chk("en_width", 32'(hi_cnt), 32'(TEN));
          hd_left = THD - 1;
        end else if (hd_left > 0) begin
          chk("hold", 32'(bus), 32'(held));
          hd_left--;
        end
        for (int i = TSU - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus;
        en_d = LCD_EN;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin : stim
    int n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    do_init();
    send(1'b1, 8'h41, 0, 1'b0);
    send(1'b0, 8'h80, 3, 1'b1);
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("no_late_write", 32'(exp_q.size()), 32'd0);
    req_rs = 1'b1; req_data = 8'h7E; req_valid = 1'b1;
    wait_ready("accept_rst");
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_xfer(1'b1, 8'h7E, 0);
    while (!(LCD_EN && !LCD_RW) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("en_in_write", 32'(LCD_EN), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en_drop", 32'(LCD_EN), 32'd0);
    chk("rst_oe_drop", 32'(LCD_DQ_OE), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_again");
    do_init();
    send(1'b0, 8'h01, 1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
